// File: rtl/seq_detect_moore_param_if.sv
// Serial detector bus: sample/control inputs toward the detector, detect/debug outputs back.
// Combinational bundle only; no latency or flow control of its own.
interface seq_detect_moore_param_if #(
    parameter int ST_W  = 3,
    parameter int CNT_W = 8
);
    logic             en;
    logic             x;
    logic             overlap;
    logic             clr_cnt;
    logic             y;
    logic [ST_W-1:0]  outstate;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, x, overlap, clr_cnt,
        input  y, outstate, match_cnt, cnt_sat
    );

    modport slave (
        input  en, x, overlap, clr_cnt,
        output y, outstate, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial pattern detector with a saturating match counter; y rises one cycle after the final bit.
// No backpressure: a bit is consumed on every clock where en=1, otherwise state and counter hold.
module seq_detect_moore_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               CNT_W   = 8,
    parameter int               ST_W    = $clog2(PAT_W+1)
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_detect_moore_param_if.slave bus
);

    typedef enum logic [ST_W-1:0] {
        S_IDLE = '0,
        S_FULL = ST_W'(PAT_W)
    } state_t;

    // Longest pattern prefix that is a suffix of (first k pattern bits, b), capped at PAT_W.
    function automatic logic [ST_W-1:0] fallback(input int k, input logic b);
        int               jmax;
        int               res;
        int               i;
        logic             ok;
        logic             sb;
        logic             pb;
        logic [PAT_W-1:0] tmp;
        jmax = (k + 1 > PAT_W) ? PAT_W : k + 1;
        res  = 0;
        for (int j = 1; j <= PAT_W; j++) begin
            if (j <= jmax) begin
                ok = 1'b1;
                for (int m = 0; m < PAT_W; m++) begin
                    if (m < j) begin
                        i  = k + 1 - j + m;
                        sb = b;
                        if (i < k) begin
                            tmp = PATTERN >> (PAT_W - 1 - i);
                            sb  = tmp[0];
                        end
                        tmp = PATTERN >> (PAT_W - 1 - m);
                        pb  = tmp[0];
                        if (sb != pb) ok = 1'b0;
                    end
                end
                if (ok) res = j;
            end
        end
        return ST_W'(res);
    endfunction

    logic [ST_W-1:0] nxt0 [PAT_W+1];
    logic [ST_W-1:0] nxt1 [PAT_W+1];

    for (genvar k = 0; k <= PAT_W; k++) begin : g_tbl
        assign nxt0[k] = fallback(k, 1'b0);
        assign nxt1[k] = fallback(k, 1'b1);
    end

    state_t           state;
    state_t           state_nxt;
    logic             hit;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             sat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        if (bus.en) begin
            if (state == S_FULL && !bus.overlap) begin
                // Non-overlapping: the completed match is forgotten entirely.
                state_nxt = (bus.x == PATTERN[PAT_W-1]) ? state_t'(ST_W'(1)) : S_IDLE;
            end else begin
                state_nxt = state_t'(bus.x ? nxt1[state] : nxt0[state]);
            end
            hit = (state_nxt == S_FULL);
        end
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (hit && cnt_q != '1) cnt_nxt = cnt_q + CNT_W'(1);
    end

    // Clear wins over a coincident detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else if (bus.clr_cnt) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            sat_q <= sat_q | (cnt_nxt == '1);
        end
    end

    assign bus.y         = (state == S_FULL);
    assign bus.outstate  = state;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
- Parametrised Moore-type serial pattern detector.
- Successor to the fixed 4-bit 1101 overlapping detector.
- Adds the following over it:
  - pattern value and length set by parameter;
  - run-time overlap / non-overlap mode;
  - enable;
  - async active-low reset;
  - saturating match counter with synchronous clear.
- Sits on a 1-bit serial data stream; `y` and `outstate` go to downstream control and debug.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- PATTERN, 4'b1101, PAT_W-bit pattern. MSB is the first bit received.
- CNT_W, 8, width of the match counter.
- ST_W, $clog2(PAT_W+1), state/outstate width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sample enable; x is consumed only when en=1
- x  in  1  serial data bit
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- clr_cnt  in  1  synchronous clear of match_cnt and cnt_sat
- y  out  1  Moore detect output
- outstate  out  ST_W  current FSM state (number of pattern bits matched)
- match_cnt  out  CNT_W  number of detections since reset/clear
- cnt_sat  out  1  sticky flag: match_cnt has reached all-ones

Behaviour:
- Reset (rst_n=0, async, takes effect immediately, including mid-sequence):
  - state=0, y=0, outstate=0, match_cnt=0, cnt_sat=0.
  - Release is synchronous to the next clk edge.
- States S0..S_PAT_W. State Sk means the last k consumed bits equal the first k bits of PATTERN (longest such k). outstate = k.
- Transition on posedge clk with en=1, consuming bit b=x:
  - From Sk, k<PAT_W: next = largest j ≤ k+1 such that the last j bits of (PATTERN[PAT_W-1 -: k], b) equal PATTERN[PAT_W-1 -: j]. This is KMP fallback; j=0 if none.
  - From S_PAT_W with overlap=1: same rule applied to (PATTERN, b), with j ≤ PAT_W. For self-overlapping patterns such as 1111 the FSM may remain in S_PAT_W.
  - From S_PAT_W with overlap=0: history is discarded. next = S1 if b==PATTERN[PAT_W-1], else S0.
- Fallback targets are computed at elaboration (function or generate). No run-time history shift register is required, but one is permitted if the behaviour is identical.
- en=0: state holds; x ignored; no count change.
- overlap is sampled every cycle. It only affects transitions out of S_PAT_W, and a mid-stream change takes effect on the next such transition.
- y = (state==S_PAT_W). It depends on state only (Moore) and asserts the cycle after the edge that consumed the final pattern bit.
- y stays high for exactly one cycle per detection, unless the FSM re-enters S_PAT_W, or en=0 holds it there.
- Counting:
  - A detection is any enabled edge whose next state is S_PAT_W. That edge increments match_cnt by 1, visible the same cycle y rises.
  - Saturation: when match_cnt == all-ones, it holds and cnt_sat=1. cnt_sat stays set until clr_cnt or reset.
  - clr_cnt=1: match_cnt<=0 and cnt_sat<=0 on the edge. Clear has priority over a simultaneous detection, so that detection is not counted. The FSM is unaffected.
- All outputs are registered or decoded from registered state only; no combinational path from x to any output.

Test Plan:
1. Defaults, overlap=1, en=1. Drive x=1,1,0,1,1,0,1 (changing on negedge) → outstate 1,2,3,4,2,3,4; y high after bit 4 and after bit 7; match_cnt=2.
2. Same stream with overlap=0 → outstate 1,2,3,4,1,0,1; y high once; match_cnt=1.
3. PAT_W=4, PATTERN=4'b1111, overlap=1. Drive six 1s → y high for 3 consecutive cycles; match_cnt=3. With overlap=0 → match_cnt=1.
4. Defaults. Drive 1,1,0, then en=0 for 3 cycles with x toggling, then en=1 and x=1 → outstate holds 3 through the gap; y high after the final 1; match_cnt=1.
5. CNT_W=2. Produce 5 detections → match_cnt sequence 1,2,3,3,3; cnt_sat=1 from the 3rd detection on. Then clr_cnt=1 on the same edge as the 6th detection → match_cnt=0, cnt_sat=0, y=1.
6. Assert rst_n=0 mid-cycle while in S3 → outstate=0 and y=0 immediately, without waiting for a clock edge. After release, the stream 1,1,0,1 detects normally.
